// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: a clock-enable divider steps a pixel position counter,
// and every output is registered from the position the counters move to on that same edge.
module vga_timing_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       i_clk,
   input  logic       i_reset,
   output logic [9:0] o_x,
   output logic [8:0] o_y,
   output logic       o_active,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_pix_tick,
   output logic       o_frame_start,
   output logic [7:0] o_frame_count
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [4:0]  DIV_LAST   = 5'(CLK_DIV - 1);
   localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
   localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
   localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [4:0] r_div;
   logic [9:0] r_h_count;
   logic [9:0] r_v_count;
   logic [9:0] r_x;
   logic [8:0] r_y;
   logic       r_active;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_pix_tick;
   logic       r_frame_start;
   logic [7:0] r_frame_count;

   logic        w_adv;
   logic        w_h_wrap;
   logic        w_first;
   logic [9:0]  w_h_next;
   logic [9:0]  w_v_next;
   logic [10:0] w_h_ext;
   logic [10:0] w_v_ext;
   logic        w_active;
   logic        w_hsync;
   logic        w_vsync;

   // Decode is done on the next position so registered outputs line up with the counters.
   always_comb begin
      w_adv    = (r_div == DIV_LAST);
      w_h_wrap = (r_h_count == H_LAST);
      w_h_next = w_h_wrap ? 10'd0 : r_h_count + 10'd1;
      w_v_next = r_v_count;
      if (w_h_wrap) begin
         w_v_next = (r_v_count == V_LAST) ? 10'd0 : r_v_count + 10'd1;
      end
      w_h_ext  = {1'b0, w_h_next};
      w_v_ext  = {1'b0, w_v_next};
      w_active = (w_h_ext < H_VIS) && (w_v_ext < V_VIS);
      w_hsync  = !((w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END));
      w_vsync  = !((w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END));
      w_first  = (w_h_next == 10'd0) && (w_v_next == 10'd0);
   end

   // Counters park on the last position so the first advance after reset enters (0,0).
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_div         <= 5'd0;
         r_h_count     <= H_LAST;
         r_v_count     <= V_LAST;
         r_x           <= 10'd0;
         r_y           <= 9'd0;
         r_active      <= 1'b0;
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_pix_tick    <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= 8'd0;
      end else begin
         r_pix_tick    <= w_adv;
         r_frame_start <= w_adv && w_first;
         if (w_adv) begin
            r_div     <= 5'd0;
            r_h_count <= w_h_next;
            r_v_count <= w_v_next;
            r_x       <= w_active ? w_h_next : 10'd0;
            r_y       <= w_active ? w_v_next[8:0] : 9'd0;
            r_active  <= w_active;
            r_hsync   <= w_hsync;
            r_vsync   <= w_vsync;
            if (w_first) begin
               r_frame_count <= r_frame_count + 8'd1;
            end
         end else begin
            r_div <= r_div + 5'd1;
         end
      end
   end

   assign o_x           = r_x;
   assign o_y           = r_y;
   assign o_active      = r_active;
   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_pix_tick    = r_pix_tick;
   assign o_frame_start = r_frame_start;
   assign o_frame_count = r_frame_count;
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 2: system clocks per pixel; legal range 1..16.
REQ-002 Parameter H_VISIBLE, default 640: visible pixels per line.
REQ-003 Parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48: horizontal porch and sync widths in pixels.
REQ-004 Parameter V_VISIBLE, default 480: visible lines per frame.
REQ-005 Parameters V_FRONT/V_SYNC/V_BACK, defaults 10/2/33: vertical porch and sync widths in lines.
REQ-006 H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK, V_TOTAL likewise; both SHALL be <=1024; H_VISIBLE<=1024, V_VISIBLE<=512.
REQ-007 clk  input  1  system clock, one clock domain, rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 x  output  10  current pixel column, feeds display tile decoders.
REQ-010 y  output  9  current pixel row.
REQ-011 active  output  1  high while the current pixel is in the visible region.
REQ-012 hsync  output  1  horizontal sync, active low.
REQ-013 vsync  output  1  vertical sync, active low.
REQ-014 pix_tick  output  1  one-clk pulse marking the first clk of each new pixel.
REQ-015 frame_start  output  1  one-clk pulse on the first pixel of each frame.
REQ-016 frame_count  output  8  frames started since reset, modulo 256.

Function
REQ-017 Internal divider div counts 0..CLK_DIV-1; an advance occurs on each edge where div==CLK_DIV-1, and div returns to 0 at that edge.
REQ-018 With CLK_DIV=1, every clk edge is an advance.
REQ-019 Internal h_count (0..H_TOTAL-1) and v_count (0..V_TOTAL-1) hold the current pixel position.
REQ-020 On an advance, h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments; v_count at V_TOTAL-1 wraps to 0 at the same edge.
REQ-021 All outputs SHALL be registered and describe the position held in (h_count, v_count) after the same edge; no output path is combinational from counters.
REQ-022 active = (h_count < H_VISIBLE) and (v_count < V_VISIBLE).
REQ-023 x = h_count and y = v_count[8:0] when active; x = 0 and y = 0 when not active.
REQ-024 hsync = 0 iff H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC; else 1.
REQ-025 vsync = 0 iff V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC, over whole lines, independent of h_count.
REQ-026 pix_tick = 1 for exactly the clk cycle following each advance edge; with CLK_DIV=1 it stays high after the first advance.
REQ-027 frame_start = 1 for exactly one clk cycle following the advance edge that enters (0,0).
REQ-028 frame_count increments at the same edge frame_start rises; 255 wraps to 0.
REQ-029 Outputs are held constant between advances.

Reset
REQ-030 While reset is high, asynchronously and without a clk edge: div=0, h_count=H_TOTAL-1, v_count=V_TOTAL-1.
REQ-031 Reset output values: x=0, y=0, active=0, hsync=1, vsync=1, pix_tick=0, frame_start=0, frame_count=0.
REQ-032 The first advance after reset release SHALL enter (0,0), producing frame_start and frame_count=1.
REQ-033 Reset asserted mid-line or mid-frame SHALL abandon the current frame with no partial sync pulse stretched.

Verification
REQ-034 Defaults: release reset, clock 2 edges -> 2nd edge: x=0, y=0, active=1, frame_start and pix_tick high 1 clk, frame_count=1.
REQ-035 Defaults, one line -> hsync low for exactly 96 advances (192 clks) starting at h=656; line = 1600 clks.
REQ-036 Defaults, one frame -> vsync low for exactly 1600 advances starting at line 490; frame_start period = 420000 advances.
REQ-037 At h=640 and at v=480 -> active=0, x=0, y=0; at (639,479) -> x=639, y=479, active=1.
REQ-038 Small params (H 4/1/1/1, V 2/1/1/1, CLK_DIV=1), run 257 frames -> frame_count 255 wraps to 0 then 1.
REQ-039 Assert reset mid-line between clk edges -> outputs take reset values immediately; release -> timing restarts per REQ-034.
